// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, hex segment table and scan state type for the 7-segment scanner
package seg7_pkg;

    // All-off patterns for the active-low segment and digit-select buses
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] SEL_OFF = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a} glyphs; dp is off in every entry
    localparam logic [7:0] HEX_SEG_0 = 8'hC0;
    localparam logic [7:0] HEX_SEG_1 = 8'hF9;
    localparam logic [7:0] HEX_SEG_2 = 8'hA4;
    localparam logic [7:0] HEX_SEG_3 = 8'hB0;
    localparam logic [7:0] HEX_SEG_4 = 8'h99;
    localparam logic [7:0] HEX_SEG_5 = 8'h92;
    localparam logic [7:0] HEX_SEG_6 = 8'h82;
    localparam logic [7:0] HEX_SEG_7 = 8'hF8;
    localparam logic [7:0] HEX_SEG_8 = 8'h80;
    localparam logic [7:0] HEX_SEG_9 = 8'h90;
    localparam logic [7:0] HEX_SEG_A = 8'h88;
    localparam logic [7:0] HEX_SEG_B = 8'h83;
    localparam logic [7:0] HEX_SEG_C = 8'hC6;
    localparam logic [7:0] HEX_SEG_D = 8'hA1;
    localparam logic [7:0] HEX_SEG_E = 8'h86;
    localparam logic [7:0] HEX_SEG_F = 8'h8E;

    // BLANK: anti-ghosting gap at the start of a slot; DRIVE: digit lit
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational 4-bit hex to active-low 7-segment glyph lookup
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    // Table lookup; every entry keeps the decimal point dark
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = HEX_SEG_0;
            4'h1: seg = HEX_SEG_1;
            4'h2: seg = HEX_SEG_2;
            4'h3: seg = HEX_SEG_3;
            4'h4: seg = HEX_SEG_4;
            4'h5: seg = HEX_SEG_5;
            4'h6: seg = HEX_SEG_6;
            4'h7: seg = HEX_SEG_7;
            4'h8: seg = HEX_SEG_8;
            4'h9: seg = HEX_SEG_9;
            4'hA: seg = HEX_SEG_A;
            4'hB: seg = HEX_SEG_B;
            4'hC: seg = HEX_SEG_C;
            4'hD: seg = HEX_SEG_D;
            4'hE: seg = HEX_SEG_E;
            4'hF: seg = HEX_SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 8-digit multiplexed hex display scanner with inter-digit blanking (option: SEG7_LEADING_ZERO_BLANK_EN)
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [31:0] i_data,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        scan_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

    logic [31:0]    data_reg;
    logic [CW-1:0]  div_cnt;
    logic [CW-1:0]  div_next;
    logic           div_wrap;
    logic [2:0]     digit_idx;
    scan_state_t    state;
    scan_state_t    state_next;
    logic [3:0]     nibble;
    logic [7:0]     dec_seg;
    logic [7:0]     sel_onehot;
    logic [7:0]     drive_seg;

    // Slot divider next value and the phase it lands in; the state register
    // therefore always describes the div_cnt value held alongside it
    always_comb begin
        div_wrap   = (div_cnt == DIV_LAST);
        div_next   = div_wrap ? '0 : div_cnt + CW'(1);
        state_next = (int'(div_next) < BLANK_CYCLES) ? BLANK : DRIVE;
    end

    // Pick the active digit's nibble and its low-going select line
    always_comb begin
        nibble     = data_reg[{digit_idx, 2'b00} +: 4];
        sel_onehot = ~(8'b1 << digit_idx);
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg    (dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lead_zero;

    // A digit is a leading zero when it and everything above it are zero;
    // digit 0 is exempt so an all-zero word still shows a single 0
    always_comb begin
        lead_zero = (digit_idx != 3'd0) && ((data_reg >> {digit_idx, 2'b00}) == 32'd0);
        drive_seg = lead_zero ? SEG_OFF : dec_seg;
    end
`else
    // Every digit is shown, leading zeros included
    always_comb begin
        drive_seg = dec_seg;
    end
`endif

    // Latch, divider, digit counter, phase FSM and registered display outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg  <= 32'd0;
            div_cnt   <= '0;
            digit_idx <= 3'd0;
            state     <= BLANK;
            o_seg     <= SEG_OFF;
            o_sel     <= SEL_OFF;
            scan_tick <= 1'b0;
        end else begin
            if (cs) begin
                data_reg <= i_data;
            end
            div_cnt <= div_next;
            if (div_wrap) begin
                digit_idx <= digit_idx + 3'd1;
            end
            state     <= state_next;
            scan_tick <= div_wrap;
            case (state)
                DRIVE: begin
                    o_sel <= sel_onehot;
                    o_seg <= drive_seg;
                end
                default: begin
                    o_sel <= SEL_OFF;
                    o_seg <= SEG_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - directed self-checking bench for seg7_scan_display
module tb_seg7_scan_display;

    logic        clk;
    logic        rst;
    logic        cs;
    logic [31:0] i_data;
    logic [7:0]  seg_a, sel_a, seg_b, sel_b;
    logic        tick_a, tick_b;

    int errors;
    int checks;

    logic [7:0] exp_seg [8];

    seg7_scan_display #(.SCAN_DIV(4), .BLANK_CYCLES(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .i_data    (i_data),
        .o_seg     (seg_a),
        .o_sel     (sel_a),
        .scan_tick (tick_a)
    );

    seg7_scan_display #(.SCAN_DIV(2), .BLANK_CYCLES(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .i_data    (i_data),
        .o_seg     (seg_b),
        .o_sel     (sel_b),
        .scan_tick (tick_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset, then release with cs=1 so the word loads on the first posedge;
    // returns at the negedge after that posedge with cs dropped
    task automatic reset_load(input logic [31:0] val);
        @(negedge clk);
        rst    = 1'b0;
        cs     = 1'b1;
        i_data = val;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cs = 1'b0;
    endtask

    // Walk 32 clocks of dut_a (4 clocks/slot, 1 blank) against exp_seg
    task automatic check_full_scan_a(input string tag);
        logic [7:0] esel, eseg;
        logic       etick;
        for (int n = 1; n <= 32; n++) begin
            int k, ph;
            if (n > 1) @(negedge clk);
            k  = (n - 1) / 4;
            ph = (n - 1) % 4;
            if (ph == 0) begin
                esel = 8'hFF;
                eseg = 8'hFF;
            end else begin
                esel = ~(8'b1 << k);
                eseg = exp_seg[k];
            end
            etick = (ph == 3);
            checks++;
            if (sel_a !== esel) begin
                errors++;
                $display("FAIL %s sel cycle %0d: got %h expected %h", tag, n, sel_a, esel);
            end
            checks++;
            if (seg_a !== eseg) begin
                errors++;
                $display("FAIL %s seg cycle %0d: got %h expected %h", tag, n, seg_a, eseg);
            end
            checks++;
            if (tick_a !== etick) begin
                errors++;
                $display("FAIL %s tick cycle %0d: got %b expected %b", tag, n, tick_a, etick);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst    = 1'b0;
        cs     = 1'b1;
        i_data = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (seg_a !== 8'hFF) begin errors++; $display("FAIL reset seg: got %h expected ff", seg_a); end
            checks++;
            if (sel_a !== 8'hFF) begin errors++; $display("FAIL reset sel: got %h expected ff", sel_a); end
            checks++;
            if (tick_a !== 1'b0) begin errors++; $display("FAIL reset tick: got %b expected 0", tick_a); end
        end
        cs  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sel_a !== 8'hFF) begin errors++; $display("FAIL reset first blank sel: got %h expected ff", sel_a); end
        @(negedge clk);
        checks++;
        if (sel_a !== 8'hFE) begin errors++; $display("FAIL reset digit0 sel: got %h expected fe", sel_a); end
        checks++;
        if (seg_a !== 8'hC0) begin errors++; $display("FAIL reset digit0 seg: got %h expected c0", seg_a); end
    endtask

    task automatic test_scan_order();
        reset_load(32'h0123ABCD);
        exp_seg = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        exp_seg[7] = 8'hFF;
`endif
        check_full_scan_a("scan_order");
    endtask

    task automatic test_live_update();
        @(negedge clk);
        rst    = 1'b0;
        cs     = 1'b1;
        i_data = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (seg_a !== 8'hC0 || sel_a !== 8'hFE) begin
            errors++;
            $display("FAIL live before: got seg %h sel %h expected c0 fe", seg_a, sel_a);
        end
        i_data = 32'hF;
        @(negedge clk);
        checks++;
        if (seg_a !== 8'hC0 || sel_a !== 8'hFE) begin
            errors++;
            $display("FAIL live load edge: got seg %h sel %h expected c0 fe", seg_a, sel_a);
        end
        @(negedge clk);
        checks++;
        if (seg_a !== 8'h8E || sel_a !== 8'hFE) begin
            errors++;
            $display("FAIL live after: got seg %h sel %h expected 8e fe", seg_a, sel_a);
        end
        cs = 1'b0;
    endtask

    task automatic test_boundary();
        logic [7:0] esel;
        reset_load(32'h76543210);
        exp_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
        for (int n = 1; n <= 20; n++) begin
            int k;
            if (n > 1) @(negedge clk);
            if (n >= 2) begin
                k    = ((n - 1) / 2) % 8;
                esel = ~(8'b1 << k);
                checks++;
                if (sel_b === 8'hFF) begin
                    errors++;
                    $display("FAIL boundary blanked cycle %0d: got sel ff", n);
                end
                checks++;
                if (sel_b !== esel || seg_b !== exp_seg[k]) begin
                    errors++;
                    $display("FAIL boundary cycle %0d: got sel %h seg %h expected sel %h seg %h",
                             n, sel_b, seg_b, esel, exp_seg[k]);
                end
            end
            if (n == 16) begin
                checks++;
                if (sel_b !== 8'h7F) begin errors++; $display("FAIL boundary wrap last: got %h expected 7f", sel_b); end
            end
            if (n == 17) begin
                checks++;
                if (sel_b !== 8'hFE) begin errors++; $display("FAIL boundary wrap first: got %h expected fe", sel_b); end
            end
        end
    endtask

    task automatic test_async_reset();
        reset_load(32'h0123ABCD);
        for (int n = 2; n <= 22; n++) @(negedge clk);
        checks++;
        if (sel_a !== 8'hDF || seg_a !== 8'hA4) begin
            errors++;
            $display("FAIL async pre digit5: got sel %h seg %h expected df a4", sel_a, seg_a);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (sel_a !== 8'hFF || seg_a !== 8'hFF || tick_a !== 1'b0) begin
            errors++;
            $display("FAIL async immediate: got sel %h seg %h tick %b expected ff ff 0", sel_a, seg_a, tick_a);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sel_a !== 8'hFF) begin errors++; $display("FAIL async restart blank: got %h expected ff", sel_a); end
        @(negedge clk);
        checks++;
        if (sel_a !== 8'hFE || seg_a !== 8'hC0) begin
            errors++;
            $display("FAIL async restart digit0: got sel %h seg %h expected fe c0", sel_a, seg_a);
        end
    endtask

    task automatic test_leading_zero();
        reset_load(32'h00000A00);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        exp_seg = '{8'hC0, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
        exp_seg = '{8'hC0, 8'hC0, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        check_full_scan_a("lz_a00");
        reset_load(32'h0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
        exp_seg = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        check_full_scan_a("lz_zero");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        cs     = 1'b0;
        i_data = 32'h0;
        test_reset();
        test_scan_order();
        test_live_update();
        test_boundary();
        test_async_reset();
        test_leading_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
